// File: rtl/game_physics.sv
// Flappy-style game state engine: bird physics, one scrolling pipe, scoring and collision.
// Latency: one UPDATE cycle per frame tick, then one draw_frame pulse to the painter.
// Backpressure: the painter stalls the game by withholding draw_done; ticks meanwhile collapse into one pending update.
module game_physics #(
  parameter int FRAME_DIV = 833333,
  parameter int GAP       = 32,
  parameter int FLAP_V    = 4,
  parameter int MAX_FALL  = 4
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       flap,
  input  logic       draw_done,
  output logic       draw_frame,
  output logic [6:0] box_y,
  output logic [7:0] pipe_1_x,
  output logic [6:0] pipe_1_y,
  output logic [7:0] score,
  output logic       game_over
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(FRAME_DIV - 1);
  localparam logic signed [4:0] FLAP_VEL = 5'(-FLAP_V);
  localparam logic signed [4:0] FALL_VEL = 5'(MAX_FALL);
  localparam logic [8:0]        GAP_LAST = 9'(GAP - 1);

  typedef enum logic [2:0] {
    IDLE, RUN_WAIT, UPDATE, DRAW_REQ, DRAW_WAIT, DEAD
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic              tick;
  logic              tick_pending;
  logic              flap_q, flap_rise, flap_pending;
  logic [6:0]        lfsr;
  logic signed [4:0] vel;
  logic              collide;

  logic              load_init, do_update;
  logic signed [8:0] ny;
  logic [6:0]        upd_by, upd_py;
  logic [7:0]        upd_px;
  logic signed [4:0] vel_base, vel_inc, upd_vel;
  logic              floor_hit, in_cols, above, below, hit;

  assign tick      = (cnt == CNT_LAST);
  assign flap_rise = flap & ~flap_q;

  // Free-running frame divider, tick pending latch, flap edge capture and LFSR
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt          <= '0;
      tick_pending <= 1'b0;
      flap_q       <= 1'b0;
      flap_pending <= 1'b0;
      lfsr         <= 7'h5A;
    end else begin
      cnt    <= tick ? '0 : cnt + 1'b1;
      flap_q <= flap;
      lfsr   <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      if (state == RUN_WAIT)
        tick_pending <= 1'b0;
      else if (tick)
        tick_pending <= 1'b1;
      if (state == UPDATE)
        flap_pending <= flap_rise;
      else if (flap_rise)
        flap_pending <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Next-state logic and per-state strobes
  always_comb begin
    state_n    = state;
    draw_frame = 1'b0;
    load_init  = 1'b0;
    do_update  = 1'b0;
    case (state)
      IDLE, DEAD: begin
        if (start) begin
          load_init = 1'b1;
          state_n   = DRAW_REQ;
        end
      end
      RUN_WAIT: begin
        if (tick || tick_pending)
          state_n = UPDATE;
      end
      UPDATE: begin
        do_update = 1'b1;
        state_n   = DRAW_REQ;
      end
      DRAW_REQ: begin
        draw_frame = 1'b1;
        state_n    = DRAW_WAIT;
      end
      DRAW_WAIT: begin
        if (draw_done)
          state_n = collide ? DEAD : RUN_WAIT;
      end
      default: state_n = IDLE;
    endcase
  end

  // One frame of physics computed from the current state; committed only in UPDATE
  always_comb begin
    ny        = $signed({2'b00, box_y}) + $signed({{4{vel[4]}}, vel});
    upd_by    = box_y;
    vel_base  = vel;
    floor_hit = 1'b0;
    if (ny >= 9'sd118) begin
      upd_by    = 7'd118;
      floor_hit = 1'b1;
    end else if (ny < 9'sd1) begin
      upd_by   = 7'd1;
      vel_base = '0;
    end else begin
      upd_by = ny[6:0];
    end
    vel_inc = vel_base + 5'sd1;
    if (flap_pending)
      upd_vel = FLAP_VEL;
    else if (vel_inc > FALL_VEL)
      upd_vel = FALL_VEL;
    else
      upd_vel = vel_inc;
    if (pipe_1_x == 8'd0) begin
      upd_px = 8'd159;
      upd_py = 7'd10 + {1'b0, lfsr[5:0]};
    end else begin
      upd_px = pipe_1_x - 8'd1;
      upd_py = pipe_1_y;
    end
    // Bird spans rows upd_by-1..upd_by+1; written with +1 on the other side to avoid underflow
    in_cols = (upd_px >= 8'd3) && (upd_px <= 8'd5);
    above   = {2'b00, upd_by} < ({2'b00, upd_py} + 9'd1);
    below   = ({2'b00, upd_by} + 9'd1) > ({2'b00, upd_py} + GAP_LAST);
    hit     = floor_hit | (in_cols & (above | below));
  end

  // Game values: reinitialised on start, advanced once per UPDATE, otherwise held for the painter
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      box_y     <= 7'd60;
      vel       <= '0;
      pipe_1_x  <= 8'd159;
      pipe_1_y  <= 7'd40;
      score     <= 8'd0;
      collide   <= 1'b0;
      game_over <= 1'b0;
    end else if (load_init) begin
      box_y     <= 7'd60;
      vel       <= '0;
      pipe_1_x  <= 8'd159;
      pipe_1_y  <= 7'd40;
      score     <= 8'd0;
      collide   <= 1'b0;
      game_over <= 1'b0;
    end else if (do_update) begin
      box_y     <= upd_by;
      vel       <= upd_vel;
      pipe_1_x  <= upd_px;
      pipe_1_y  <= upd_py;
      if (pipe_1_x == 8'd3)
        score <= score + 8'd1;
      collide   <= collide | hit;
      game_over <= game_over | hit;
    end
  end

endmodule
